// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two memory requesters, the shared memory port and the arbiter.
// The master side drives requests and memory read data; the slave side is the arbiter.
interface mem_port_arbiter_if #(
  parameter int N = 32
);
  logic         core_req;
  logic         core_we;
  logic [N-1:0] core_addr;
  logic [N-1:0] core_wdata;
  logic         core_gnt;
  logic         core_rvalid;

  logic         dma_req;
  logic         dma_we;
  logic [N-1:0] dma_addr;
  logic [N-1:0] dma_wdata;
  logic         dma_lock;
  logic         dma_gnt;
  logic         dma_rvalid;

  logic [N-1:0] rdata;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_we;
  logic [N-1:0] mem_rdata;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    output mem_rdata,
    input  core_gnt, core_rvalid, dma_gnt, dma_rvalid,
    input  rdata, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    input  mem_rdata,
    output core_gnt, core_rvalid, dma_gnt, dma_rvalid,
    output rdata, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core and a DMA/loader,
// with a DMA burst lock that is released after LOCK_MAX beats (LOCK_MAX in 1..255).
module mem_port_arbiter #(
  parameter int N        = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [0:0] ARB    = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  logic [0:0] state;
  logic       last_gnt;    // 0 = core, 1 = DMA
  logic [7:0] lock_cnt;
  logic       core_rv_q;
  logic       dma_rv_q;

  logic         core_gnt_c;
  logic         dma_gnt_c;
  logic         lock_hit;
  logic         starve;
  logic         release_c;
  logic [N-1:0] sel_addr;
  logic [N-1:0] sel_wdata;

  // NOTE: every output of a combinational block is given a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    core_gnt_c = 1'b0;
    dma_gnt_c  = 1'b0;
    if (!rst) begin
      if (state == LOCKED) begin
        dma_gnt_c = bus.dma_req;
      end else if (bus.core_req && bus.dma_req) begin
        core_gnt_c = last_gnt;
        dma_gnt_c  = !last_gnt;
      end else begin
        core_gnt_c = bus.core_req;
        dma_gnt_c  = bus.dma_req;
      end
    end
  end

  // Forced releases hand the next conflict to the core.
  assign lock_hit  = dma_gnt_c && ((lock_cnt + 8'd1) == LOCK_MAX_C);
  assign starve    = !bus.dma_req && bus.core_req;
  assign release_c = !bus.dma_lock || lock_hit || starve;

  assign sel_addr  = dma_gnt_c ? bus.dma_addr  : bus.core_addr;
  assign sel_wdata = dma_gnt_c ? bus.dma_wdata : bus.core_wdata;

  assign bus.core_gnt    = core_gnt_c;
  assign bus.dma_gnt     = dma_gnt_c;
  assign bus.mem_addr    = sel_addr;
  assign bus.mem_wdata   = sel_wdata;
  assign bus.mem_we      = (core_gnt_c && bus.core_we) || (dma_gnt_c && bus.dma_we);
  assign bus.rdata       = bus.mem_rdata;
  // A reset arriving while a read is in flight cancels its response at once.
  assign bus.core_rvalid = core_rv_q && !rst;
  assign bus.dma_rvalid  = dma_rv_q && !rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      last_gnt  <= 1'b1;
      lock_cnt  <= 8'd0;
      core_rv_q <= 1'b0;
      dma_rv_q  <= 1'b0;
    end else begin
      core_rv_q <= core_gnt_c && !bus.core_we;
      dma_rv_q  <= dma_gnt_c && !bus.dma_we;

      if (core_gnt_c) begin
        last_gnt <= 1'b0;
      end else if (dma_gnt_c) begin
        last_gnt <= 1'b1;
      end

      case (state)
        ARB: begin
          // With LOCK_MAX = 1 the locking beat is already the last one.
          if (dma_gnt_c && bus.dma_lock && (LOCK_MAX > 1)) begin
            state    <= LOCKED;
            lock_cnt <= 8'd1;
          end
        end
        LOCKED: begin
          if (dma_gnt_c) begin
            lock_cnt <= lock_cnt + 8'd1;
          end
          if (release_c) begin
            state    <= ARB;
            lock_cnt <= 8'd0;
            if (lock_hit || starve) begin
              last_gnt <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ARB;
          lock_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule
